imem_port_arbiter: RTL and testbench

//  Shares the single instruction-memory port between two requesters:
//  - F: the multi-cycle control unit's instruction fetch (read-only)
//  - L: the program loader/debug port (read/write), used to load and verify code

---
 rtl/imem_port_arbiter.sv | 152 +++++++++++++++
 tb/tb_imem_port_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_port_arbiter.sv
// Two-master arbiter for the single instruction-memory port: fetch (F, read-only) and
// loader/debug (L, read/write). Strobes are registered; each access takes a grant and an access edge.
module imem_port_arbiter #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MEM_DEPTH = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ack,
  output logic [DATA_W-1:0] f_rdata,
  output logic              f_err,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  input  logic              l_lock,
  output logic              l_ack,
  output logic [DATA_W-1:0] l_rdata,
  output logic              l_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StAccF, StAccL} state_e;

  state_e            state_q, state_d;
  logic              last_l_q, last_l_d;
  logic              err_q, err_d;
  logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              f_ack_q, f_ack_d, f_err_q, f_err_d;
  logic              l_ack_q, l_ack_d, l_err_q, l_err_d;
  logic [DATA_W-1:0] f_rdata_q, f_rdata_d, l_rdata_q, l_rdata_d;
  logic              f_elig, l_elig, grant_f, grant_l, f_oor, l_oor;

  always_comb begin
    f_oor = (f_addr >= ADDR_W'(MEM_DEPTH));
    l_oor = (l_addr >= ADDR_W'(MEM_DEPTH));
    // A requester acked on the previous edge is skipped so a held req is not granted twice;
    // while L holds the lock after its own grant, F is kept off the port entirely.
    f_elig  = f_req & ~f_ack_q & ~(last_l_q & l_lock);
    l_elig  = l_req & ~l_ack_q;
    grant_f = f_elig & (~l_elig | last_l_q);
    grant_l = l_elig & ~grant_f;

    state_d     = state_q;
    last_l_d    = last_l_q;
    err_d       = err_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    f_ack_d     = 1'b0;
    l_ack_d     = 1'b0;
    f_err_d     = f_err_q;
    l_err_d     = l_err_q;
    f_rdata_d   = f_rdata_q;
    l_rdata_d   = l_rdata_q;

    unique case (state_q)
      StIdle: begin
        if (grant_f) begin
          state_d     = StAccF;
          last_l_d    = 1'b0;
          err_d       = f_oor;
          mem_en_d    = ~f_oor;
          mem_we_d    = 1'b0;
          mem_addr_d  = f_addr;
          mem_wdata_d = '0;
        end else if (grant_l) begin
          state_d     = StAccL;
          last_l_d    = 1'b1;
          err_d       = l_oor;
          mem_en_d    = ~l_oor;
          mem_we_d    = l_we & ~l_oor;
          mem_addr_d  = l_addr;
          mem_wdata_d = l_wdata;
        end
      end
      StAccF: begin
        f_ack_d   = 1'b1;
        f_err_d   = err_q;
        f_rdata_d = err_q ? '0 : mem_rdata;
        mem_en_d  = 1'b0;
        mem_we_d  = 1'b0;
        state_d   = StIdle;
      end
      StAccL: begin
        l_ack_d   = 1'b1;
        l_err_d   = err_q;
        l_rdata_d = (err_q | mem_we_q) ? '0 : mem_rdata;
        mem_en_d  = 1'b0;
        mem_we_d  = 1'b0;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      last_l_q    <= 1'b1;
      err_q       <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      f_ack_q     <= 1'b0;
      l_ack_q     <= 1'b0;
      f_err_q     <= 1'b0;
      l_err_q     <= 1'b0;
      f_rdata_q   <= '0;
      l_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      last_l_q    <= last_l_d;
      err_q       <= err_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      f_ack_q     <= f_ack_d;
      l_ack_q     <= l_ack_d;
      f_err_q     <= f_err_d;
      l_err_q     <= l_err_d;
      f_rdata_q   <= f_rdata_d;
      l_rdata_q   <= l_rdata_d;
    end
  end

  assign f_ack     = f_ack_q;
  assign f_err     = f_err_q;
  assign f_rdata   = f_rdata_q;
  assign l_ack     = l_ack_q;
  assign l_err     = l_err_q;
  assign l_rdata   = l_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Bench for imem_port_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level model (service order, memory contents, error rules).
module tb_imem_port_arbiter;

  logic        clk, rst_n;
  logic        f_req, f_ack, f_err, l_req, l_we, l_lock, l_ack, l_err;
  logic [31:0] f_addr, f_rdata, l_addr, l_wdata, l_rdata;
  logic        mem_en, mem_we, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] mem [1024];
  logic        bd_we;
  logic [9:0]  bd_addr;
  logic [31:0] bd_data;
  int total = 0;
  int bad = 0;

  imem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_DEPTH(1024)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata), .f_err(f_err),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata), .l_lock(l_lock),
    .l_ack(l_ack), .l_rdata(l_rdata), .l_err(l_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: combinational read, write on the clock edge; bd_* is a preload path.
  assign mem_rdata = (mem_addr < 32'd1024) ? mem[mem_addr[9:0]] : 32'h0;
  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (mem_en && mem_we && mem_addr < 32'd1024) mem[mem_addr[9:0]] <= mem_wdata;
  end

  task automatic preload(input int a, input logic [31:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_addr = 10'(a); bd_data = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    f_req = 1'b0; f_addr = '0; l_req = 1'b0; l_we = 1'b0; l_addr = '0; l_wdata = '0;
    l_lock = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic f_access(input logic [31:0] a, output logic [31:0] d, output logic e,
                          output int cyc);
    f_req = 1'b1; f_addr = a; cyc = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (f_ack) begin cyc = c; break; end
    end
    d = f_rdata; e = f_err; f_req = 1'b0;
  endtask

  task automatic l_access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] d, output logic e, output int cyc);
    l_req = 1'b1; l_we = we; l_addr = a; l_wdata = wd; cyc = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (l_ack) begin cyc = c; break; end
    end
    d = l_rdata; e = l_err; l_req = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({f_ack, l_ack, f_err, l_err, mem_en, mem_we, busy} !== 7'b0) begin
      bad++; $display("FAIL reset_flags: got %b want 0000000",
                      {f_ack, l_ack, f_err, l_err, mem_en, mem_we, busy});
    end
    total++;
    if ({f_rdata, l_rdata, mem_addr, mem_wdata} !== 128'h0) begin
      bad++; $display("FAIL reset_data: got %h want 0", {f_rdata, l_rdata, mem_addr, mem_wdata});
    end
  endtask

  task automatic test_basic_fetch();
    logic [31:0] d; logic e; int cyc;
    preload(0, 32'h08CA0052);
    do_reset();
    f_access(32'd0, d, e, cyc);
    total++;
    if (cyc !== 2) begin bad++; $display("FAIL fetch_latency: got %0d want 2", cyc); end
    total++;
    if (d !== 32'h08CA0052) begin bad++; $display("FAIL fetch_data: got %h want 08ca0052", d); end
    total++;
    if (e !== 1'b0) begin bad++; $display("FAIL fetch_err: got %b want 0", e); end
  endtask

  task automatic test_write_then_read();
    logic [31:0] d; logic e; int cyc;
    do_reset();
    l_access(1'b1, 32'd7, 32'h07FFFFEC, d, e, cyc);
    total++;
    if ({cyc, d, e} !== {32'd2, 32'h0, 1'b0}) begin
      bad++; $display("FAIL l_write: got cyc=%0d rdata=%h err=%b want cyc=2 rdata=0 err=0",
                      cyc, d, e);
    end
    @(negedge clk);
    f_req = 1'b1; f_addr = 32'd7;
    @(negedge clk);
    total++;
    if ({busy, mem_en, mem_we} !== 3'b110) begin
      bad++; $display("FAIL f_access_strobes: got busy/en/we=%b want 110", {busy, mem_en, mem_we});
    end
    @(negedge clk);
    f_req = 1'b0;
    total++;
    if ({f_ack, f_rdata} !== {1'b1, 32'h07FFFFEC}) begin
      bad++; $display("FAIL f_read_back: got ack=%b rdata=%h want ack=1 rdata=07ffffec",
                      f_ack, f_rdata);
    end
  endtask

  task automatic test_alternate();
    bit seq[$]; bit pf, pl, dbl;
    do_reset();
    f_req = 1'b1; f_addr = 32'd0; l_req = 1'b1; l_we = 1'b0; l_addr = 32'd7;
    pf = 0; pl = 0; dbl = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (f_ack && l_ack) dbl = 1;
      if ((f_ack && pf) || (l_ack && pl)) dbl = 1;
      if (f_ack) seq.push_back(1'b0);
      if (l_ack) seq.push_back(1'b1);
      pf = f_ack; pl = l_ack;
    end
    f_req = 1'b0; l_req = 1'b0;
    total++;
    if (seq.size() < 4) begin
      bad++; $display("FAIL alt_count: got %0d acks want >=4", seq.size());
    end else begin
      total++;
      if ({seq[0], seq[1], seq[2], seq[3]} !== 4'b0101) begin
        bad++; $display("FAIL alt_order: got %b want 0101 (0=F,1=L)",
                        {seq[0], seq[1], seq[2], seq[3]});
      end
    end
    total++;
    if (dbl !== 1'b0) begin bad++; $display("FAIL alt_single_ack: got %b want 0", dbl); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_lock();
    int nl, cyc; bit f_early; logic [31:0] d; logic e;
    do_reset();
    f_req = 1'b1; f_addr = 32'd5; l_lock = 1'b1;
    l_req = 1'b1; l_we = 1'b1; l_addr = 32'd8; l_wdata = 32'hA5000000;
    nl = 0; f_early = 0; cyc = 0;
    while (nl < 4 && cyc < 40) begin
      @(negedge clk); cyc++;
      if (f_ack) f_early = 1;
      if (l_ack) begin
        nl++;
        if (nl < 4) begin l_addr = 32'd8 + 32'(nl); l_wdata = 32'hA5000000 + 32'(nl); end
        else begin l_req = 1'b0; l_lock = 1'b0; end
      end
    end
    total++;
    if (nl !== 4) begin bad++; $display("FAIL lock_l_count: got %0d want 4", nl); end
    total++;
    if (f_early !== 1'b0) begin bad++; $display("FAIL lock_f_early: got %b want 0", f_early); end
    cyc = 0;
    while (!f_ack && cyc < 10) begin @(negedge clk); cyc++; end
    f_req = 1'b0;
    total++;
    if (cyc !== 2) begin bad++; $display("FAIL lock_release_latency: got %0d want 2", cyc); end
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      f_access(32'd8 + 32'(i), d, e, cyc);
      total++;
      if (d !== 32'hA5000000 + 32'(i)) begin
        bad++; $display("FAIL lock_write_%0d: got %h want %h", i, d, 32'hA5000000 + 32'(i));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_out_of_range();
    bit en_seen; int cyc; logic [31:0] d; logic e;
    do_reset();
    f_req = 1'b1; f_addr = 32'd1024; en_seen = 0; cyc = -1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (mem_en) en_seen = 1;
      if (f_ack) begin cyc = c; break; end
    end
    f_req = 1'b0;
    total++;
    if ({cyc, f_err, f_rdata, en_seen} !== {32'd2, 1'b1, 32'h0, 1'b0}) begin
      bad++; $display("FAIL oor_fetch: got cyc=%0d err=%b rdata=%h en=%b want 2 1 0 0",
                      cyc, f_err, f_rdata, en_seen);
    end
    @(negedge clk);
    l_access(1'b1, 32'd1023, 32'h1234_5678, d, e, cyc);
    @(negedge clk);
    l_access(1'b1, 32'd1024, 32'hDEAD_BEEF, d, e, cyc);
    total++;
    if ({e, d} !== {1'b1, 32'h0}) begin
      bad++; $display("FAIL oor_write: got err=%b rdata=%h want 1 0", e, d);
    end
    @(negedge clk);
    l_access(1'b0, 32'd1023, 32'h0, d, e, cyc);
    total++;
    if ({e, d} !== {1'b0, 32'h1234_5678}) begin
      bad++; $display("FAIL edge_addr_read: got err=%b rdata=%h want 0 12345678", e, d);
    end
  endtask

  task automatic test_reset_mid_access();
    bit l_seen; bit first_l; int cyc; logic [31:0] d; logic e;
    preload(20, 32'h1111_2222);
    do_reset();
    l_req = 1'b1; l_we = 1'b1; l_addr = 32'd20; l_wdata = 32'h3333_4444;
    @(negedge clk);
    total++;
    if ({busy, mem_we} !== 2'b11) begin
      bad++; $display("FAIL abort_pre: got busy/we=%b want 11", {busy, mem_we});
    end
    #1 rst_n = 1'b0; l_req = 1'b0;
    #1;
    total++;
    if ({busy, mem_we, mem_en} !== 3'b000) begin
      bad++; $display("FAIL abort_async: got busy/we/en=%b want 000", {busy, mem_we, mem_en});
    end
    l_seen = 0;
    repeat (2) begin @(negedge clk); if (l_ack) l_seen = 1; end
    rst_n = 1'b1;
    repeat (2) begin @(negedge clk); if (l_ack) l_seen = 1; end
    total++;
    if (l_seen !== 1'b0) begin bad++; $display("FAIL abort_ack: got %b want 0", l_seen); end
    f_req = 1'b1; f_addr = 32'd20; l_req = 1'b1; l_we = 1'b0; l_addr = 32'd20;
    cyc = 0; first_l = 1;
    while (!f_ack && !l_ack && cyc < 10) begin @(negedge clk); cyc++; end
    first_l = l_ack;
    total++;
    if ({f_ack, first_l, f_rdata} !== {1'b1, 1'b0, 32'h1111_2222}) begin
      bad++; $display("FAIL abort_tie: got f_ack=%b l_first=%b rdata=%h want 1 0 11112222",
                      f_ack, first_l, f_rdata);
    end
    f_req = 1'b0;
    cyc = 0;
    while (!l_ack && cyc < 10) begin @(negedge clk); cyc++; end
    l_req = 1'b0;
    @(negedge clk);
    f_access(32'd20, d, e, cyc);
    total++;
    if (d !== 32'h1111_2222) begin bad++; $display("FAIL abort_mem: got %h want 11112222", d); end
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(7) == 0) return 32'd1024 + 32'($urandom_range(3));
    return 32'($urandom_range(15));
  endfunction

  // Model: ties go to whoever was not served last; memory is a plain array updated in service order.
  task automatic test_random();
    logic [31:0] mm [16];
    logic [31:0] fa, la, wd, ef_d, el_d;
    logic ef_e, el_e, we;
    bit do_f, do_l, f_first, got_f, got_l, last_l;
    int kind, first;
    for (int i = 0; i < 16; i++) begin mm[i] = $urandom; preload(i, mm[i]); end
    do_reset();
    last_l = 1;
    for (int t = 0; t < 60; t++) begin
      kind = int'($urandom_range(2));
      do_f = (kind != 1); do_l = (kind != 0);
      fa = rand_addr(); la = rand_addr(); wd = $urandom; we = 1'($urandom_range(1));
      f_first = do_f && (!do_l || last_l);
      ef_d = '0; ef_e = 0; el_d = '0; el_e = 0;
      for (int s = 0; s < 2; s++) begin
        if ((s == 0) == f_first) begin
          if (do_f) begin
            ef_e = (fa >= 1024); ef_d = ef_e ? 32'h0 : mm[fa[3:0]]; last_l = 0;
          end
        end else if (do_l) begin
          el_e = (la >= 1024);
          if (we) begin el_d = '0; if (!el_e) mm[la[3:0]] = wd; end
          else el_d = el_e ? 32'h0 : mm[la[3:0]];
          last_l = 1;
        end
      end
      f_req = do_f; f_addr = fa; l_req = do_l; l_we = we; l_addr = la; l_wdata = wd;
      got_f = !do_f; got_l = !do_l; first = -1;
      for (int c = 0; c < 16 && !(got_f && got_l); c++) begin
        @(negedge clk);
        if (f_ack && !got_f) begin
          got_f = 1; f_req = 1'b0; if (first < 0) first = 0;
          total++;
          if ({f_err, f_rdata} !== {ef_e, ef_d}) begin
            bad++; $display("FAIL rnd%0d_f: got err=%b rdata=%h want err=%b rdata=%h",
                            t, f_err, f_rdata, ef_e, ef_d);
          end
        end
        if (l_ack && !got_l) begin
          got_l = 1; l_req = 1'b0; if (first < 0) first = 1;
          total++;
          if ({l_err, l_rdata} !== {el_e, el_d}) begin
            bad++; $display("FAIL rnd%0d_l: got err=%b rdata=%h want err=%b rdata=%h",
                            t, l_err, l_rdata, el_e, el_d);
          end
        end
      end
      f_req = 1'b0; l_req = 1'b0;
      total++;
      if ({got_f, got_l} !== 2'b11) begin
        bad++; $display("FAIL rnd%0d_timeout: got done=%b want 11", t, {got_f, got_l});
      end
      if (do_f && do_l) begin
        total++;
        if (first !== (f_first ? 0 : 1)) begin
          bad++; $display("FAIL rnd%0d_order: got first=%0d want %0d", t, first,
                          f_first ? 0 : 1);
        end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    rst_n = 1'b0; f_req = 1'b0; f_addr = '0; l_req = 1'b0; l_we = 1'b0;
    l_addr = '0; l_wdata = '0; l_lock = 1'b0;
    test_reset();
    test_basic_fetch();
    test_write_then_read();
    test_alternate();
    test_lock();
    test_out_of_range();
    test_reset_mid_access();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
